// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART baud generator slice.
//   - default field widths and reset configuration (100 MHz, 115200 baud, x16)
//   - legality limits for a runtime divisor load
//   - baud_cfg_t: the active divisor / oversampling configuration
//   - cfg_legal(): the single legality rule used wherever a load is validated
package uart_pkg;

    localparam int DIV_W_DEF        = 16;
    localparam int FRAC_W_DEF       = 4;
    localparam int OSR_W_DEF        = 5;

    localparam int MIN_DIV          = 2;
    localparam int MIN_OSR          = 4;

    localparam int RST_DIV_INT_DEF  = 54;
    localparam int RST_DIV_FRAC_DEF = 4;
    localparam int RST_OSR_DEF      = 16;

    typedef struct packed {
        logic [DIV_W_DEF-1:0]  div_int;
        logic [FRAC_W_DEF-1:0] div_frac;
        logic [OSR_W_DEF-1:0]  osr;
    } baud_cfg_t;

    // An odd OSR has no exact mid-bit tick, so it is refused along with
    // divisors too small for the counter to produce a one-cycle pulse.
    function automatic logic cfg_legal(input logic [DIV_W_DEF-1:0] div_int,
                                       input logic [OSR_W_DEF-1:0] osr);
        return (div_int >= DIV_W_DEF'(MIN_DIV)) &&
               (osr >= OSR_W_DEF'(MIN_OSR)) && !osr[0];
    endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if: config/strobe bundle between the register block / UART
// FSMs (master) and the baud generator (slave).
//   en_i, div_load_i, div_int_i, div_frac_i, osr_i, rx_resync_i : to generator
//   tick_rx_o, rx_sample_o, tick_tx_o, cfg_err_o                : from generator
interface baud_gen_frac_if
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR_W  = OSR_W_DEF
);
    logic              en_i;
    logic              div_load_i;
    logic [DIV_W-1:0]  div_int_i;
    logic [FRAC_W-1:0] div_frac_i;
    logic [OSR_W-1:0]  osr_i;
    logic              rx_resync_i;
    logic              tick_rx_o;
    logic              rx_sample_o;
    logic              tick_tx_o;
    logic              cfg_err_o;

    modport master (
        output en_i, div_load_i, div_int_i, div_frac_i, osr_i, rx_resync_i,
        input  tick_rx_o, rx_sample_o, tick_tx_o, cfg_err_o
    );

    modport slave (
        input  en_i, div_load_i, div_int_i, div_frac_i, osr_i, rx_resync_i,
        output tick_rx_o, rx_sample_o, tick_tx_o, cfg_err_o
    );
endinterface

// File: rtl/frac_prescaler.sv
// frac_prescaler: fractional clock divider, one per baud channel.
//   clk, reset_n : clock, async active-low reset
//   i_en         : count enable; low holds cnt/acc/carry
//   i_clr        : synchronous clear of all state (wins over i_en)
//   i_div_int    : integer clocks per tick
//   i_div_frac   : fractional part, in 1/2^FRAC_W clock units
//   o_tick       : registered one-cycle tick, one cycle after the last count
module frac_prescaler #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    output logic              o_tick
);
    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_c;
    logic              r_tick;

    logic [DIV_W:0]    w_len;
    logic [DIV_W:0]    w_cnt_inc;
    logic              w_last;
    logic [FRAC_W:0]   w_sum;

    // Interval is div_int clocks, stretched by one when the previous
    // accumulation overflowed. One extra bit keeps div_int+c from wrapping.
    assign w_len     = {1'b0, i_div_int} + {{DIV_W{1'b0}}, r_c};
    assign w_cnt_inc = {1'b0, r_cnt} + {{DIV_W{1'b0}}, 1'b1};
    assign w_last    = (w_cnt_inc == w_len);
    assign w_sum     = {1'b0, r_acc} + {1'b0, i_div_frac};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_c    <= 1'b0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_c    <= 1'b0;
            r_tick <= 1'b0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt        <= '0;
                {r_c, r_acc} <= w_sum;
                r_tick       <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_inc[DIV_W-1:0];
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable UART baud generator.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : en_i / div_load_i / div_int_i / div_frac_i / osr_i /
//                  rx_resync_i in; tick_rx_o / rx_sample_o / tick_tx_o /
//                  cfg_err_o out (all outputs one-cycle pulses)
// Two fractional prescalers (TX, RX) share one active config. The osr
// counters advance on the cycle a prescaler tick is visible, and the
// derived strobes are decoded from that same cycle's counter value.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W        = DIV_W_DEF,
    parameter int FRAC_W       = FRAC_W_DEF,
    parameter int OSR_W        = OSR_W_DEF,
    parameter int RST_DIV_INT  = RST_DIV_INT_DEF,
    parameter int RST_DIV_FRAC = RST_DIV_FRAC_DEF,
    parameter int RST_OSR      = RST_OSR_DEF
) (
    input logic            clk,
    input logic            reset_n,
    baud_gen_frac_if.slave bus
);
    baud_cfg_t        r_cfg;
    logic [OSR_W-1:0] r_txs;
    logic [OSR_W-1:0] r_rxs;
    logic             r_cfg_err;

    logic             w_legal;
    logic             w_load_ok;
    logic             w_clr_rx;
    logic             w_tx_tick;
    logic             w_rx_tick;
    logic [OSR_W-1:0] w_osr_last;
    logic [OSR_W-1:0] w_osr_mid;

    assign w_legal    = cfg_legal(bus.div_int_i, bus.osr_i);
    assign w_load_ok  = bus.div_load_i & w_legal;
    // An illegal load leaves the config alone but a coincident resync
    // still restarts the RX phase.
    assign w_clr_rx   = w_load_ok | bus.rx_resync_i;
    assign w_osr_last = r_cfg.osr - OSR_W'(1);
    assign w_osr_mid  = (r_cfg.osr >> 1) - OSR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg <= '{div_int:  DIV_W'(RST_DIV_INT),
                       div_frac: FRAC_W'(RST_DIV_FRAC),
                       osr:      OSR_W'(RST_OSR)};
        end else if (w_load_ok) begin
            r_cfg <= '{div_int:  bus.div_int_i,
                       div_frac: bus.div_frac_i,
                       osr:      bus.osr_i};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= bus.div_load_i & ~w_legal;
        end
    end

    frac_prescaler #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx_presc (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (bus.en_i),
        .i_clr      (w_load_ok),
        .i_div_int  (r_cfg.div_int),
        .i_div_frac (r_cfg.div_frac),
        .o_tick     (w_tx_tick)
    );

    frac_prescaler #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx_presc (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (bus.en_i),
        .i_clr      (w_clr_rx),
        .i_div_int  (r_cfg.div_int),
        .i_div_frac (r_cfg.div_frac),
        .o_tick     (w_rx_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_txs <= '0;
        end else if (w_load_ok) begin
            r_txs <= '0;
        end else if (w_tx_tick) begin
            r_txs <= (r_txs == w_osr_last) ? '0 : r_txs + OSR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxs <= '0;
        end else if (w_clr_rx) begin
            r_rxs <= '0;
        end else if (w_rx_tick) begin
            r_rxs <= (r_rxs == w_osr_last) ? '0 : r_rxs + OSR_W'(1);
        end
    end

    assign bus.tick_rx_o   = w_rx_tick;
    assign bus.rx_sample_o = w_rx_tick & (r_rxs == w_osr_mid);
    assign bus.tick_tx_o   = w_tx_tick & (r_txs == w_osr_last);
    assign bus.cfg_err_o   = r_cfg_err;
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: the reference model tracks, per channel, enabled clocks
// since the last clear and ticks produced. Tick j (1-based) ends after
// j*div_int + floor((j-1)*div_frac / 2^FRAC_W) enabled clocks and becomes
// visible one cycle later. TX strobes on ticks that are multiples of osr;
// the RX sample strobe lands on ticks where j mod osr == osr/2.
module tb_baud_gen_frac;
    import uart_pkg::*;

    localparam int FW = FRAC_W_DEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    baud_gen_frac_if bus ();

    baud_gen_frac dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int     m_d, m_f, m_o;
    longint m_n [2];
    longint m_k [2];
    longint m_i [2];
    bit     m_p [2];
    bit     m_err;
    bit     m_legal;

    function automatic longint tick_end(longint j);
        return j * m_d + (((j - 1) * m_f) >> FW);
    endfunction

    task automatic ch_clear(int ch);
        m_n[ch] = 0; m_k[ch] = 0; m_i[ch] = 0; m_p[ch] = 1'b0;
    endtask

    task automatic ch_step(int ch, bit en);
        if (en) begin
            m_n[ch]++;
            if (m_n[ch] == tick_end(m_k[ch] + 1)) begin
                m_k[ch]++;
                m_p[ch] = 1'b1;
                m_i[ch] = m_k[ch];
            end else begin
                m_p[ch] = 1'b0;
            end
        end else begin
            m_p[ch] = 1'b0;
        end
    endtask

    initial begin
        m_d = RST_DIV_INT_DEF; m_f = RST_DIV_FRAC_DEF; m_o = RST_OSR_DEF;
        ch_clear(0); ch_clear(1); m_err = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_d = RST_DIV_INT_DEF; m_f = RST_DIV_FRAC_DEF; m_o = RST_OSR_DEF;
                ch_clear(0); ch_clear(1); m_err = 1'b0;
            end else begin
                m_legal = bus.div_load_i && (bus.div_int_i >= 2) &&
                          (bus.osr_i >= 4) && (bus.osr_i % 2 == 0);
                m_err = bus.div_load_i && !m_legal;
                if (m_legal) begin
                    m_d = int'(bus.div_int_i);
                    m_f = int'(bus.div_frac_i);
                    m_o = int'(bus.osr_i);
                    ch_clear(0); ch_clear(1);
                end else begin
                    ch_step(0, bus.en_i);
                    if (bus.rx_resync_i) ch_clear(1);
                    else ch_step(1, bus.en_i);
                end
            end
        end
    end

    // Per-cycle compare: {tick_rx, rx_sample, tick_tx, cfg_err}
    initial begin
        logic [3:0] exp_v, got_v;
        forever begin
            @(negedge clk);
            exp_v = {m_p[1], m_p[1] && (m_i[1] % m_o == m_o / 2),
                     m_p[0] && (m_i[0] % m_o == 0), m_err};
            got_v = {bus.tick_rx_o, bus.rx_sample_o, bus.tick_tx_o, bus.cfg_err_o};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t {rx,samp,tx,err} got %b expected %b",
                         $time, got_v, exp_v);
            end
        end
    end

    task automatic chk(string name, longint got, longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_rx(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick_rx_o && n < 5000);
        if (!bus.tick_rx_o) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_rx: no tick_rx_o within %0d cycles", n);
        end
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick_tx_o && n < 5000);
        if (!bus.tick_tx_o) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_tx: no tick_tx_o within %0d cycles", n);
        end
    endtask

    task automatic do_load(int d, int f, int o);
        bus.div_int_i  = 16'(d);
        bus.div_frac_i = 4'(f);
        bus.osr_i      = 5'(o);
        bus.div_load_i = 1'b1;
        @(negedge clk);
        bus.div_load_i = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int w, t;
    int def_iv [5] = '{54, 54, 54, 54, 55};
    int frac_iv[5] = '{4, 4, 5, 4, 5};
    int rst_iv [4] = '{54, 54, 54, 55};

    initial begin
        bus.en_i = 1'b0; bus.div_load_i = 1'b0; bus.rx_resync_i = 1'b0;
        bus.div_int_i = '0; bus.div_frac_i = '0; bus.osr_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.tick_rx_o, bus.rx_sample_o, bus.tick_tx_o, bus.cfg_err_o}, 0);
        reset_n = 1'b1;
        bus.en_i = 1'b1;

        // defaults 54.25: 54,54,54,54,55 from release
        for (int i = 0; i < 5; i++) begin
            wait_rx(w);
            chk($sformatf("default_iv%0d", i), w, def_iv[i]);
        end
        wait_tx(w);
        wait_tx(w);
        chk("default_tx_period", w, 868);

        // 4 + 8/16, osr 8
        do_load(4, 8, 8);
        chk("legal_load_no_err", bus.cfg_err_o, 0);
        for (int i = 0; i < 5; i++) begin
            wait_rx(w);
            chk($sformatf("frac_iv%0d", i), w, frac_iv[i]);
        end
        wait_tx(w);
        wait_tx(w);
        chk("frac_tx_period", w, 36);

        // resync mid-interval at div 4/0, osr 8
        do_load(4, 0, 8);
        wait_rx(w);
        @(negedge clk);
        bus.rx_resync_i = 1'b1;
        @(negedge clk);
        bus.rx_resync_i = 1'b0;
        wait_rx(w);
        chk("resync_first_tick", w, 4);
        t = 1;
        while (!bus.rx_sample_o && t < 64) begin wait_rx(w); t++; end
        chk("resync_sample_tick_idx", t, 4);
        t = 0;
        do begin wait_rx(w); t++; end while (!bus.rx_sample_o && t < 64);
        chk("sample_period_ticks", t, 8);

        // illegal loads: one-cycle error, spacing unchanged
        do_load(1, 0, 8);
        chk("err_div1_pulse", bus.cfg_err_o, 1);
        @(negedge clk);
        chk("err_div1_clear", bus.cfg_err_o, 0);
        wait_rx(w);
        wait_rx(w);
        chk("err_div1_spacing", w, 4);
        do_load(4, 0, 7);
        chk("err_osr7_pulse", bus.cfg_err_o, 1);
        @(negedge clk);
        chk("err_osr7_clear", bus.cfg_err_o, 0);
        wait_rx(w);
        wait_rx(w);
        chk("err_osr7_spacing", w, 4);

        // enable gap at div 6
        do_load(6, 0, 8);
        wait_rx(w);
        repeat (2) @(negedge clk);
        bus.en_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.en_i = 1'b1;
        wait_rx(w);
        chk("resume_remaining", w, 4);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.en_i        = ($urandom_range(0, 9) != 0);
            bus.rx_resync_i = ($urandom_range(0, 29) == 0);
            bus.div_int_i   = 16'($urandom_range(0, 10));
            bus.div_frac_i  = 4'($urandom_range(0, 15));
            bus.osr_i       = 5'($urandom_range(0, 20));
            bus.div_load_i  = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        bus.en_i = 1'b1; bus.rx_resync_i = 1'b0; bus.div_load_i = 1'b0;

        // reset mid-interval after a load
        do_load(5, 3, 6);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs",
               {bus.tick_rx_o, bus.rx_sample_o, bus.tick_tx_o, bus.cfg_err_o}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_rx(w);
        chk("post_reset_first", w, 54);
        for (int i = 0; i < 4; i++) begin
            wait_rx(w);
            chk($sformatf("post_reset_iv%0d", i), w, rst_iv[i]);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
